// File: rtl/sha_pkg.sv
// Shared constants, state encodings and SHA-256 helpers for the authenticator.
package sha_pkg;

    localparam int unsigned DIGEST_W = 256;
    localparam int unsigned WORDS    = 8;

    localparam logic [255:0] TEST_KEY    = 256'h4c4e49536c6e69734c4e49536c6e69734c4e49536c6e69734c4e49536c6e6973;
    localparam logic [255:0] TEST_DIGEST = 256'he42c30a65a37f031fe920210a999325f84dc75c7ee90d4d2543cef1936d3fb36;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_HASH    = 3'd1,
        ST_COMPARE = 3'd2,
        ST_DONE    = 3'd3,
        ST_LOCKED  = 3'd4
    } auth_state_e;

    typedef enum logic [1:0] {
        CORE_IDLE  = 2'd0,
        CORE_ROUND = 2'd1,
        CORE_FINAL = 2'd2
    } core_state_e;

    localparam logic [31:0] K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    localparam logic [31:0] IV256 [8] = '{
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a, 32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    localparam logic [31:0] IV224 [8] = '{
        32'hc1059ed8, 32'h367cd507, 32'h3070dd17, 32'hf70e5939, 32'hffc00b31, 32'h68581511, 32'h64f98fa7, 32'hbefa4fa4
    };

    function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] big_sig0(input logic [31:0] x);
        return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
    endfunction

    function automatic logic [31:0] big_sig1(input logic [31:0] x);
        return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
    endfunction

    function automatic logic [31:0] small_sig0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] small_sig1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

endpackage

// File: rtl/sha256_core.sv
// Iterative SHA-256 core: hashes a 256-bit message (padded internally), one round per cycle.
module sha256_core
    import sha_pkg::*;
(
    input  logic                clk,
    input  logic                reset_n,
    input  logic                init,
    input  logic                next,
    input  logic                mode,
    input  logic [DIGEST_W-1:0] block,
    output logic                ready,
    output logic [DIGEST_W-1:0] digest,
    output logic                digest_valid
);

    core_state_e state_q, state_d;
    logic [31:0] h_q [8];
    logic [31:0] v_q [8];
    logic [31:0] w_q [16];
    logic [31:0] iv_c [8];
    logic [31:0] pad_c [16];
    logic [5:0]  t_q;
    logic [31:0] t1_c, t2_c, w_new_c;

    // Padded single-block message and initial hash value selection
    always_comb begin
        for (int i = 0; i < 16; i++) pad_c[i] = '0;
        for (int i = 0; i < 8; i++) begin
            pad_c[i] = block[DIGEST_W-1-32*i -: 32];
            iv_c[i]  = mode ? IV256[i] : IV224[i];
        end
        pad_c[8]  = 32'h8000_0000;
        pad_c[15] = 32'd256;
    end

    // Round function and message schedule expansion
    always_comb begin
        t1_c    = v_q[7] + big_sig1(v_q[4]) + ((v_q[4] & v_q[5]) ^ (~v_q[4] & v_q[6])) + K[t_q] + w_q[0];
        t2_c    = big_sig0(v_q[0]) + ((v_q[0] & v_q[1]) ^ (v_q[0] & v_q[2]) ^ (v_q[1] & v_q[2]));
        w_new_c = small_sig1(w_q[14]) + w_q[9] + small_sig0(w_q[1]) + w_q[0];
        digest  = '0;
        for (int i = 0; i < 8; i++) digest[DIGEST_W-1-32*i -: 32] = h_q[i];
    end

    // Control state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= CORE_IDLE;
        else          state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            CORE_IDLE:  if (init || next) state_d = CORE_ROUND;
            CORE_ROUND: if (t_q == 6'd63) state_d = CORE_FINAL;
            CORE_FINAL: state_d = CORE_IDLE;
            default:    state_d = CORE_IDLE;
        endcase
    end

    // Hash datapath and status flags
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 8; i++) begin
                h_q[i] <= '0;
                v_q[i] <= '0;
            end
            for (int i = 0; i < 16; i++) w_q[i] <= '0;
            t_q          <= '0;
            ready        <= 1'b0;
            digest_valid <= 1'b0;
        end else begin
            ready <= (state_d == CORE_IDLE);
            case (state_q)
                CORE_IDLE: begin
                    if (init || next) begin
                        for (int i = 0; i < 8; i++) begin
                            v_q[i] <= init ? iv_c[i] : h_q[i];
                            if (init) h_q[i] <= iv_c[i];
                        end
                        for (int i = 0; i < 16; i++) w_q[i] <= pad_c[i];
                        t_q          <= '0;
                        digest_valid <= 1'b0;
                    end
                end
                CORE_ROUND: begin
                    v_q[0] <= t1_c + t2_c;
                    v_q[1] <= v_q[0];
                    v_q[2] <= v_q[1];
                    v_q[3] <= v_q[2];
                    v_q[4] <= v_q[3] + t1_c;
                    v_q[5] <= v_q[4];
                    v_q[6] <= v_q[5];
                    v_q[7] <= v_q[6];
                    for (int i = 0; i < 15; i++) w_q[i] <= w_q[i+1];
                    w_q[15] <= w_new_c;
                    t_q     <= t_q + 6'd1;
                end
                CORE_FINAL: begin
                    for (int i = 0; i < 8; i++) h_q[i] <= h_q[i] + v_q[i];
                    digest_valid <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/sha_auth_multi.sv
// Hash-and-compare authenticator: hashes the block, checks it against valid digest slots,
// and locks out after MAX_FAIL consecutive failures.
module sha_auth_multi
    import sha_pkg::*;
#(
    parameter  int unsigned N_SLOTS  = 4,
    parameter  int unsigned MAX_FAIL = 3,
    localparam int unsigned SLOT_W   = (N_SLOTS > 1) ? $clog2(N_SLOTS) : 1,
    localparam int unsigned FAIL_W   = $clog2(MAX_FAIL + 1)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              we,
    input  logic              wc,
    input  logic [SLOT_W-1:0] slot,
    input  logic [2:0]        address,
    input  logic [31:0]       write_data,
    input  logic              seal,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              auth_ok,
    output logic [SLOT_W-1:0] match_slot,
    output logic              locked
);

    auth_state_e         state_q, state_d;
    logic [31:0]         block_q [WORDS];
    logic [31:0]         dig_q [N_SLOTS][WORDS];
    logic [N_SLOTS-1:0]  slot_valid_q;
    logic                sealed_q, init_q;
    logic [SLOT_W-1:0]   idx_q;
    logic [FAIL_W-1:0]   fail_cnt_q;
    logic [DIGEST_W-1:0] hash_q, core_digest, block_c, slot_dig_c;
    logic                core_ready, core_valid, slot_hit_c;
    logic                idle_c, blk_we_c, dig_we_c;

    // Write qualification and compare datapath
    always_comb begin
        idle_c     = (state_q == ST_IDLE);
        blk_we_c   = we && wc && idle_c;
        dig_we_c   = we && !wc && idle_c && !sealed_q && (32'(slot) < N_SLOTS);
        block_c    = '0;
        slot_dig_c = '0;
        for (int w = 0; w < WORDS; w++) begin
            block_c[32*w +: 32]    = block_q[w];
            slot_dig_c[32*w +: 32] = dig_q[idx_q][w];
        end
        slot_hit_c = slot_valid_q[idx_q] && (hash_q == slot_dig_c);
    end

    // Block and digest register file, seal flag
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int w = 0; w < WORDS; w++) block_q[w] <= '0;
            for (int s = 0; s < N_SLOTS; s++)
                for (int w = 0; w < WORDS; w++) dig_q[s][w] <= '0;
            slot_valid_q <= '0;
            sealed_q     <= 1'b0;
        end else begin
            if (seal) sealed_q <= 1'b1;
            if (blk_we_c) block_q[address] <= write_data;
            if (dig_we_c) begin
                dig_q[slot][address] <= write_data;
                if (address == 3'd7) slot_valid_q[slot] <= 1'b1;
            end
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    // FSM next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (start) state_d = ST_HASH;
            ST_HASH:    if (!init_q && core_ready && core_valid) state_d = ST_COMPARE;
            ST_COMPARE: if (slot_hit_c || (idx_q == SLOT_W'(N_SLOTS - 1))) state_d = ST_DONE;
            ST_DONE:    state_d = (fail_cnt_q >= FAIL_W'(MAX_FAIL)) ? ST_LOCKED : ST_IDLE;
            ST_LOCKED:  state_d = ST_LOCKED;
            default:    state_d = ST_IDLE;
        endcase
    end

    // Registered outputs, verdict, fail counter and captured digest
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            busy       <= 1'b0;
            done       <= 1'b0;
            auth_ok    <= 1'b0;
            match_slot <= '0;
            locked     <= 1'b0;
            init_q     <= 1'b0;
            idx_q      <= '0;
            fail_cnt_q <= '0;
            hash_q     <= '0;
        end else begin
            busy   <= (state_d == ST_HASH) || (state_d == ST_COMPARE);
            done   <= (state_d == ST_DONE);
            locked <= (state_d == ST_LOCKED);
            init_q <= idle_c && (state_d == ST_HASH);
            idx_q  <= (state_q == ST_COMPARE) ? idx_q + SLOT_W'(1) : '0;
            if (idle_c && start) auth_ok <= 1'b0;
            if ((state_q == ST_HASH) && (state_d == ST_COMPARE)) hash_q <= core_digest;
            if ((state_q == ST_COMPARE) && (state_d == ST_DONE)) begin
                auth_ok    <= slot_hit_c;
                match_slot <= slot_hit_c ? idx_q : '0;
                fail_cnt_q <= slot_hit_c ? '0 : fail_cnt_q + FAIL_W'(1);
            end
            if (state_d == ST_LOCKED) auth_ok <= 1'b0;
        end
    end

    sha256_core u_core (
        .clk          (clk),
        .reset_n      (reset_n),
        .init         (init_q),
        .next         (1'b0),
        .mode         (1'b1),
        .block        (block_c),
        .ready        (core_ready),
        .digest       (core_digest),
        .digest_valid (core_valid)
    );

endmodule

// File: tb/tb_sha_auth_multi.sv
// Scoreboard bench for sha_auth_multi: stimulus pushes expected verdicts, a monitor checks each done.
module tb_sha_auth_multi;
    import sha_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        we = 1'b0, wc = 1'b0, seal = 1'b0, start = 1'b0;
    logic [1:0]  slot = '0;
    logic [2:0]  address = '0;
    logic [31:0] write_data = '0;
    logic        busy, done, auth_ok, locked;
    logic [1:0]  match_slot;

    typedef struct packed {
        logic       ok;
        logic [1:0] sl;
    } exp_t;

    exp_t         exp_q [$];
    int           n_cmp = 0;
    int           n_bad = 0;
    int           cmp_total = 0;
    logic [255:0] good_dig;

    sha_auth_multi #(.N_SLOTS(4), .MAX_FAIL(3)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .we         (we),
        .wc         (wc),
        .slot       (slot),
        .address    (address),
        .write_data (write_data),
        .seal       (seal),
        .start      (start),
        .busy       (busy),
        .done       (done),
        .auth_ok    (auth_ok),
        .match_slot (match_slot),
        .locked     (locked)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1);
    end

    function automatic logic [31:0] ror(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    // Straight-line reference SHA-256 of a 32-byte message
    function automatic logic [255:0] sha_ref(input logic [255:0] msg);
        logic [31:0] w [64];
        logic [31:0] hv [8];
        logic [31:0] a, b, c, d, e, f, g, h, t1, t2, s0, s1;
        logic [255:0] out;
        hv = '{32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
               32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
        for (int i = 0; i < 8; i++) w[i] = msg[255-32*i -: 32];
        w[8] = 32'h80000000;
        for (int i = 9; i < 15; i++) w[i] = 32'h0;
        w[15] = 32'd256;
        for (int i = 16; i < 64; i++) begin
            s0 = ror(w[i-15], 7) ^ ror(w[i-15], 18) ^ (w[i-15] >> 3);
            s1 = ror(w[i-2], 17) ^ ror(w[i-2], 19) ^ (w[i-2] >> 10);
            w[i] = w[i-16] + s0 + w[i-7] + s1;
        end
        a = hv[0]; b = hv[1]; c = hv[2]; d = hv[3];
        e = hv[4]; f = hv[5]; g = hv[6]; h = hv[7];
        for (int i = 0; i < 64; i++) begin
            t1 = h + (ror(e, 6) ^ ror(e, 11) ^ ror(e, 25)) + ((e & f) ^ (~e & g)) + K[i] + w[i];
            t2 = (ror(a, 2) ^ ror(a, 13) ^ ror(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
            h = g; g = f; f = e; e = d + t1;
            d = c; c = b; b = a; a = t1 + t2;
        end
        out = {hv[0] + a, hv[1] + b, hv[2] + c, hv[3] + d,
               hv[4] + e, hv[5] + f, hv[6] + g, hv[7] + h};
        return out;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s actual=%0h required=%0h @%0t", name, act, req, $time);
        end
    endtask

    // Monitor: counts COMPARE cycles and scores every done pulse
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (dut.state_q == ST_COMPARE) cmp_total++;
            if (reset_n && done) begin
                if (exp_q.size() == 0) begin
                    check("done_unexpected", 64'(done), 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("verdict_auth_ok", 64'(auth_ok), 64'(e.ok));
                    check("verdict_match_slot", 64'(match_slot), 64'(e.sl));
                end
            end
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic wr(input logic c, input logic [1:0] s, input logic [2:0] a, input logic [31:0] d);
        we = 1'b1; wc = c; slot = s; address = a; write_data = d;
        tick();
        we = 1'b0;
    endtask

    task automatic load_key(input logic [255:0] k, input int n);
        for (int i = 0; i < n; i++) wr(1'b1, 2'd0, 3'(i), k[32*i +: 32]);
    endtask

    task automatic load_slot(input logic [1:0] s, input logic [255:0] d);
        for (int i = 0; i < 8; i++) wr(1'b0, s, 3'(i), d[32*i +: 32]);
    endtask

    task automatic go(input logic expect_done, input logic ok, input logic [1:0] sl);
        exp_t e;
        e.ok = ok;
        e.sl = sl;
        if (expect_done) exp_q.push_back(e);
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic settle();
        repeat (100) tick();
        check("pending_verdicts", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        repeat (2) tick();
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_auth_ok", 64'(auth_ok), 64'd0);
        check("rst_match_slot", 64'(match_slot), 64'd0);
        check("rst_locked", 64'(locked), 64'd0);
        check("rst_fail_cnt", 64'(dut.fail_cnt_q), 64'd0);
        reset_n = 1'b1;
        tick();
    endtask

    initial begin
        int mark;
        logic [1:0] pass_slot;
        good_dig  = sha_ref(TEST_KEY);
        pass_slot = (good_dig == TEST_DIGEST) ? 2'd2 : 2'd3;
        tick();
        do_reset();

        // Match: TEST_DIGEST in slot 2, reference digest of the key in slot 3
        load_key(TEST_KEY, 8);
        load_slot(2'd2, TEST_DIGEST);
        load_slot(2'd3, good_dig);
        go(1'b1, 1'b1, pass_slot);
        check("busy_after_start", 64'(busy), 64'd1);
        settle();
        check("pass_fail_cnt", 64'(dut.fail_cnt_q), 64'd0);
        check("pass_auth_ok_held", 64'(auth_ok), 64'd1);
        check("pass_match_slot_held", 64'(match_slot), 64'(pass_slot));

        // Start clears the old verdict; start and write while busy are ignored
        go(1'b1, 1'b1, pass_slot);
        check("start_clears_auth_ok", 64'(auth_ok), 64'd0);
        repeat (3) tick();
        we = 1'b1; wc = 1'b1; address = 3'd0; write_data = 32'hdead_beef; start = 1'b1;
        tick();
        we = 1'b0; start = 1'b0;
        settle();
        check("busy_write_ignored", 64'(dut.block_q[0]), 64'(TEST_KEY[31:0]));

        // Single invalid-bit mismatch in slot 0: fail after scanning all slots
        do_reset();
        load_key(TEST_KEY, 8);
        load_slot(2'd0, TEST_DIGEST ^ 256'd1);
        mark = cmp_total;
        go(1'b1, 1'b0, 2'd0);
        settle();
        check("compare_cycles", 64'(cmp_total - mark), 64'd4);
        check("fail1_cnt", 64'(dut.fail_cnt_q), 64'd1);
        check("fail1_locked", 64'(locked), 64'd0);

        // Lockout on the third consecutive failure
        go(1'b1, 1'b0, 2'd0);
        settle();
        check("fail2_locked", 64'(locked), 64'd0);
        check("fail2_cnt", 64'(dut.fail_cnt_q), 64'd2);
        go(1'b1, 1'b0, 2'd0);
        settle();
        check("fail3_locked", 64'(locked), 64'd1);
        check("fail3_auth_ok", 64'(auth_ok), 64'd0);
        load_slot(2'd1, good_dig);
        check("locked_write_ignored", 64'(dut.slot_valid_q[1]), 64'd0);
        go(1'b0, 1'b0, 2'd0);
        settle();
        check("locked_busy", 64'(busy), 64'd0);
        check("locked_held", 64'(locked), 64'd1);

        // Sealed slots are read-only
        do_reset();
        load_key(TEST_KEY, 8);
        seal = 1'b1;
        tick();
        seal = 1'b0;
        load_slot(2'd1, good_dig);
        check("sealed_slot_valid", 64'(dut.slot_valid_q[1]), 64'd0);
        go(1'b1, 1'b0, 2'd0);
        settle();

        // Reset mid-hash aborts without a verdict
        do_reset();
        load_key(TEST_KEY, 8);
        load_slot(2'd0, good_dig);
        go(1'b0, 1'b0, 2'd0);
        repeat (2) tick();
        do_reset();
        settle();
        check("abort_auth_ok", 64'(auth_ok), 64'd0);

        // Fresh authentication after abort; last key word written with start
        load_key(TEST_KEY, 7);
        load_slot(2'd0, good_dig);
        exp_q.push_back('{ok: 1'b1, sl: 2'd0});
        we = 1'b1; wc = 1'b1; address = 3'd7; write_data = TEST_KEY[255:224]; start = 1'b1;
        tick();
        we = 1'b0; start = 1'b0;
        settle();
        check("post_abort_auth_ok", 64'(auth_ok), 64'd1);
        check("post_abort_fail_cnt", 64'(dut.fail_cnt_q), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/sha_auth_multi.md
SHA_AUTH_MULTI -- requirements
Module: sha_auth_multi

Interface
REQ-001 SHALL have parameter N_SLOTS, default 4, number of reference digest slots (1..16).
REQ-002 SHALL have parameter MAX_FAIL, default 3, consecutive failed authentications before lockout (1..15).
REQ-003 SHALL have port clk, input, 1, rising-edge clock for all state.
REQ-004 SHALL have port reset_n, input, 1, reset, asynchronous, active-low.
REQ-005 SHALL have port we, input, 1, write strobe for the register file.
REQ-006 SHALL have port wc, input, 1, write target: 1 = block word, 0 = digest slot word.
REQ-007 SHALL have port slot, input, clog2(N_SLOTS) (min 1), digest slot index for writes with wc=0.
REQ-008 SHALL have port address, input, 3, 32-bit word index; word 0 = bits 31:0.
REQ-009 SHALL have port write_data, input, 32, write payload.
REQ-010 SHALL have port seal, input, 1, pulse that makes all digest slots read-only until reset.
REQ-011 SHALL have port start, input, 1, request to hash the block and authenticate.
REQ-012 SHALL have port busy, output, 1, high in HASH or COMPARE.
REQ-013 SHALL have port done, output, 1, one-cycle pulse when a verdict is produced.
REQ-014 SHALL have port auth_ok, output, 1, verdict of the last completed authentication.
REQ-015 SHALL have port match_slot, output, clog2(N_SLOTS), index of the matching slot; valid when auth_ok=1.
REQ-016 SHALL have port locked, output, 1, lockout active.

Function
REQ-017 SHALL accept a write to block word address when we=1, wc=1, and state is IDLE.
REQ-018 SHALL accept a write to digest slot[slot] word address when we=1, wc=0, state IDLE, and not sealed; the write is ignored otherwise.
REQ-019 SHALL set slot_valid[slot] when word 7 of that slot is written; a slot with slot_valid=0 SHALL never match.
REQ-020 SHALL ignore an out-of-range slot index (slot >= N_SLOTS) with no state change.
REQ-021 SHALL use FSM states IDLE, HASH, COMPARE, DONE, LOCKED.
REQ-022 SHALL, on start=1 in IDLE, transition to HASH and drive the core init high for exactly the first HASH cycle (mode=1, next=0).
REQ-023 SHALL ignore start in all states other than IDLE.
REQ-024 SHALL, in HASH from the second cycle onward, capture the core digest and enter COMPARE on the first cycle where core ready=1 and digest_valid=1.
REQ-025 SHALL, in COMPARE, test one slot per cycle with index 0..N_SLOTS-1 (full 256-bit equality), and on the first match go to DONE with auth_ok=1 and match_slot set to that index.
REQ-026 SHALL go to DONE with auth_ok=0 and match_slot=0 after slot N_SLOTS-1 is tested without a match, so COMPARE lasts at most N_SLOTS cycles.
REQ-027 SHALL, on a pass, clear a fail counter of width clog2(MAX_FAIL+1); on a fail, increment it.
REQ-028 SHALL assert done for the single DONE cycle, then go to IDLE, or to LOCKED if fail_cnt has reached MAX_FAIL.
REQ-029 SHALL keep auth_ok and match_slot stable from DONE until the next accepted start, and clear auth_ok on that start.
REQ-030 SHALL, in LOCKED, hold locked=1 and auth_ok=0, ignore start and all writes, and exit only on reset.
REQ-031 SHALL give a simultaneous we and start in IDLE priority to the write, with start still accepted the same cycle; the hashed block includes that write.

Reset
REQ-032 SHALL, on reset_n low, set state IDLE, busy=0, done=0, auth_ok=0, match_slot=0, locked=0, fail_cnt=0, seal flag=0, all slot_valid=0, and all block and digest words to 0.
REQ-033 SHALL abort an operation in progress when reset is asserted mid-HASH or mid-COMPARE, produce no done pulse, and re-assert core reset_n.

Structure
REQ-034 SHALL place constants in a shared package sha_pkg: DIGEST_W=256, WORDS=8, FSM state encoding, TEST_KEY=256'h4c4e49536c6e69734c4e49536c6e69734c4e49536c6e69734c4e49536c6e6973, TEST_DIGEST=256'he42c30a65a37f031fe920210a999325f84dc75c7ee90d4d2543cef1936d3fb36.
REQ-035 SHALL instantiate exactly one sub-module, sha256_core, with block driven from {word7..word0}.

Verification
REQ-036 SHALL cover: TEST_DIGEST in slot 2, TEST_KEY in the block, start -> done once, auth_ok=1, match_slot=2, fail_cnt=0.
REQ-037 SHALL cover: TEST_DIGEST with bit 0 flipped in slot 0, others invalid, start -> auth_ok=0, and COMPARE lasts exactly N_SLOTS cycles.
REQ-038 SHALL cover: MAX_FAIL=3 with three failing starts -> locked=1 after the third done, and a fourth start with a correct digest is ignored (no done).
REQ-039 SHALL cover: seal pulse, then a write of TEST_DIGEST to slot 1 -> slot_valid[1]=0, and start yields auth_ok=0.
REQ-040 SHALL cover: reset_n low two cycles after start -> no done, all outputs 0, and a new start authenticates normally.
REQ-041 SHALL cover: start while busy, and we while busy -> both ignored; block contents unchanged.
